// File: rtl/asic_bridge_pkg.sv
// Shared definitions for the ASIC configuration loader: host command
// bytes, error cause codes, FSM state encoding and a counter-width helper.
package asic_bridge_pkg;

  localparam logic [7:0] CMD_STAT = 8'h53;
  localparam logic [7:0] CMD_DYN  = 8'h44;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_MISMATCH = 3'd1;
  localparam logic [2:0] ERR_BYTE_TO  = 3'd2;
  localparam logic [2:0] ERR_END_TO   = 3'd3;
  localparam logic [2:0] ERR_BAD_CMD  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_LAUNCH   = 3'd2,
    ST_WAIT_END = 3'd3,
    ST_CHECK    = 3'd4
  } state_t;

  // Bits needed to hold the values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cfg_frame_shifter.sv
// Shadow register for one configuration frame plus the count of payload
// bytes still expected. Bytes enter at the bottom and push older bytes up,
// so the first byte of an N-byte frame ends in the top byte of the low
// N*8 bits.
module cfg_frame_shifter #(
  parameter int WIDTH = 88,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic [CNT_W-1:0] i_load_count,
  input  logic             i_shift,
  input  logic [7:0]       i_byte,
  output logic [WIDTH-1:0] o_shadow,
  output logic             o_last_byte
);

  logic [WIDTH-1:0] r_shadow;
  logic [CNT_W-1:0] r_remaining;

  // Parallel load starts a frame; each shift appends one byte and counts down.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shadow    <= '0;
      r_remaining <= '0;
    end else if (i_load) begin
      r_shadow    <= i_load_data;
      r_remaining <= i_load_count;
    end else if (i_shift) begin
      r_shadow <= WIDTH'({r_shadow, i_byte});
      if (r_remaining != '0) begin
        r_remaining <= r_remaining - CNT_W'(1);
      end
    end
  end

  assign o_shadow    = r_shadow;
  // High while the next accepted byte completes the frame.
  assign o_last_byte = (r_remaining == CNT_W'(1));

endmodule

// File: rtl/asic_cfg_loader.sv
// Receives framed configuration bytes from the host, launches the bridge
// write of the static or dynamic register and checks its readback.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | waiting for a command byte (0x53 static, 0x44 dynamic)
// ST_LOAD     | shifting payload bytes into the shadow, byte timer running
// ST_LAUNCH   | one cycle: commit shadow, pulse start_ASIC_config
// ST_WAIT_END | waiting for a rising end_config, end timer running
// ST_CHECK    | one cycle: sample readback mismatch, pulse done
module asic_cfg_loader
  import asic_bridge_pkg::*;
#(
  parameter int SIZESRSTAT   = 88,
  parameter int SIZESRDYN    = 16,
  parameter int BYTE_TIMEOUT = 16000,
  parameter int END_TIMEOUT  = 65535
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [SIZESRSTAT-1:0] static_conf_ear,
  output logic [SIZESRDYN-1:0]  dynamic_conf,
  output logic                  flag_stat,
  output logic                  flag_dyn,
  output logic                  start_ASIC_config,
  input  logic                  end_config,
  input  logic                  xor_out_stat,
  input  logic                  xor_out_dyn,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic [2:0]            err_code
);

  localparam int SHADOW_W = (SIZESRSTAT > SIZESRDYN) ? SIZESRSTAT : SIZESRDYN;
  localparam int N_STAT   = SIZESRSTAT / 8;
  localparam int N_DYN    = SIZESRDYN / 8;
  localparam int BCNT_W   = cnt_width(SHADOW_W / 8);
  localparam int BTMR_W   = cnt_width(BYTE_TIMEOUT);
  localparam int ETMR_W   = cnt_width(END_TIMEOUT);

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_target_stat;
  logic [BTMR_W-1:0]     r_byte_tmr;
  logic [ETMR_W-1:0]     r_end_tmr;
  logic                  r_end_q;
  logic [SIZESRSTAT-1:0] r_static;
  logic [SIZESRDYN-1:0]  r_dynamic;
  logic                  r_done;
  logic                  r_cfg_err;
  logic [2:0]            r_err_code;

  logic                  w_xfer;
  logic                  w_load;
  logic                  w_shift;
  logic                  w_last_byte;
  logic [SHADOW_W-1:0]   w_shadow;
  logic                  w_err_set;
  logic [2:0]            w_err_val;
  logic                  w_done_set;
  logic                  w_end_rise;
  logic                  w_mismatch;
  logic                  w_in_launch;

  cfg_frame_shifter #(
    .WIDTH (SHADOW_W),
    .CNT_W (BCNT_W)
  ) u_shifter (
    .clk          (CLK),
    .rst_n        (RST_N),
    .i_load       (w_load),
    .i_load_data  ({SHADOW_W{1'b0}}),
    .i_load_count ((rx_data == CMD_STAT) ? BCNT_W'(N_STAT) : BCNT_W'(N_DYN)),
    .i_shift      (w_shift),
    .i_byte       (rx_data),
    .o_shadow     (w_shadow),
    .o_last_byte  (w_last_byte)
  );

  assign rx_ready   = (r_state == ST_IDLE) || (r_state == ST_LOAD);
  assign w_xfer     = rx_valid && rx_ready;
  assign w_end_rise = end_config && !r_end_q;
  assign w_mismatch = r_target_stat ? xor_out_stat : xor_out_dyn;

  // Flags cover the whole launch, from LAUNCH through CHECK.
  assign w_in_launch = (r_state == ST_LAUNCH) || (r_state == ST_WAIT_END) ||
                       (r_state == ST_CHECK);
  assign flag_stat         = w_in_launch && r_target_stat;
  assign flag_dyn          = w_in_launch && !r_target_stat;
  assign start_ASIC_config = (r_state == ST_LAUNCH);
  assign busy              = (r_state != ST_IDLE);

  assign static_conf_ear = r_static;
  assign dynamic_conf    = r_dynamic;
  assign done            = r_done;
  assign cfg_err         = r_cfg_err;
  assign err_code        = r_err_code;

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode, shifter control and error/done decisions.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_err_set    = 1'b0;
    w_err_val    = ERR_NONE;
    w_done_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          if ((rx_data == CMD_STAT) || (rx_data == CMD_DYN)) begin
            w_load       = 1'b1;
            w_next_state = ST_LOAD;
          end else begin
            w_err_set = 1'b1;
            w_err_val = ERR_BAD_CMD;
          end
        end
      end
      ST_LOAD: begin
        if (w_xfer) begin
          w_shift = 1'b1;
          if (w_last_byte) begin
            w_next_state = ST_LAUNCH;
          end
        end else if (r_byte_tmr == '0) begin
          w_err_set    = 1'b1;
          w_err_val    = ERR_BYTE_TO;
          w_next_state = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        w_next_state = ST_WAIT_END;
      end
      ST_WAIT_END: begin
        if (w_end_rise) begin
          w_next_state = ST_CHECK;
        end else if (r_end_tmr == '0) begin
          w_err_set    = 1'b1;
          w_err_val    = ERR_END_TO;
          w_next_state = ST_IDLE;
        end
      end
      ST_CHECK: begin
        w_done_set   = 1'b1;
        w_next_state = ST_IDLE;
        if (w_mismatch) begin
          w_err_set = 1'b1;
          w_err_val = ERR_MISMATCH;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Target selection, saturating down-timers and end_config edge history.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_target_stat <= 1'b0;
      r_byte_tmr    <= '0;
      r_end_tmr     <= '0;
      r_end_q       <= 1'b0;
    end else begin
      if (w_load) begin
        r_target_stat <= (rx_data == CMD_STAT);
      end
      // Byte timer restarts on every accepted byte and outside LOAD.
      if ((r_state == ST_LOAD) && !w_xfer) begin
        if (r_byte_tmr != '0) begin
          r_byte_tmr <= r_byte_tmr - BTMR_W'(1);
        end
      end else begin
        r_byte_tmr <= BTMR_W'(BYTE_TIMEOUT);
      end
      if (r_state == ST_WAIT_END) begin
        if (r_end_tmr != '0) begin
          r_end_tmr <= r_end_tmr - ETMR_W'(1);
        end
      end else begin
        r_end_tmr <= ETMR_W'(END_TIMEOUT);
      end
      r_end_q <= end_config;
    end
  end

  // Committed configuration and registered status pulses.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_static   <= '0;
      r_dynamic  <= '0;
      r_done     <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      if (r_state == ST_LAUNCH) begin
        if (r_target_stat) begin
          r_static <= w_shadow[SIZESRSTAT-1:0];
        end else begin
          r_dynamic <= w_shadow[SIZESRDYN-1:0];
        end
      end
      r_done    <= w_done_set;
      r_cfg_err <= w_err_set;
      if (w_err_set) begin
        r_err_code <= w_err_val;
      end
    end
  end

endmodule

// File: tb/tb_asic_cfg_loader.sv
// Self-checking bench for asic_cfg_loader: directed frames, timeouts,
// reset aborts and randomized frames against a byte-level reference model.
module tb_asic_cfg_loader;

  localparam int SST = 88;
  localparam int SDY = 16;
  localparam int BTO = 16000;
  localparam int ETO = 65535;

  logic           CLK = 1'b0;
  logic           RST_N = 1'b0;
  logic [7:0]     rx_data = 8'h00;
  logic           rx_valid = 1'b0;
  logic           rx_ready;
  logic [SST-1:0] static_conf_ear;
  logic [SDY-1:0] dynamic_conf;
  logic           flag_stat, flag_dyn, start_ASIC_config;
  logic           end_config = 1'b0;
  logic           xor_out_stat = 1'b0;
  logic           xor_out_dyn = 1'b0;
  logic           busy, done, cfg_err;
  logic [2:0]     err_code;

  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;
  int n_cerr = 0;
  int n_start = 0;

  logic [SST-1:0] exp_stat = '0;
  logic [SDY-1:0] exp_dyn = '0;
  logic [7:0]     pl_q[$];

  asic_cfg_loader #(
    .SIZESRSTAT   (SST),
    .SIZESRDYN    (SDY),
    .BYTE_TIMEOUT (BTO),
    .END_TIMEOUT  (ETO)
  ) dut (
    .CLK               (CLK),
    .RST_N             (RST_N),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .rx_ready          (rx_ready),
    .static_conf_ear   (static_conf_ear),
    .dynamic_conf      (dynamic_conf),
    .flag_stat         (flag_stat),
    .flag_dyn          (flag_dyn),
    .start_ASIC_config (start_ASIC_config),
    .end_config        (end_config),
    .xor_out_stat      (xor_out_stat),
    .xor_out_dyn       (xor_out_dyn),
    .busy              (busy),
    .done              (done),
    .cfg_err           (cfg_err),
    .err_code          (err_code)
  );

  always #5 CLK = ~CLK;

  // Pulse counters, sampled mid-cycle.
  always @(negedge CLK) begin
    if (done === 1'b1) n_done++;
    if (cfg_err === 1'b1) n_cerr++;
    if (start_ASIC_config === 1'b1) n_start++;
  end

  initial begin
    repeat (120000) @(posedge CLK);
    $display("FAIL watchdog: simulation exceeded 120000 cycles");
    $fatal(1, "watchdog");
  end

  // Present one byte at a negedge and return at the negedge after it transfers.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && guard < 200) begin
      @(negedge CLK);
      guard++;
    end
    n_vec++;
    if (guard >= 200) begin
      n_err++;
      $display("FAIL rx_ready_wait: byte %02h not accepted within %0d cycles", b, guard);
    end
    @(posedge CLK);
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  // Full launch of the payload in pl_q; the model value is the bytes in order.
  task automatic run_frame(input bit is_stat, input int end_delay, input bit xerr,
                           input bit hold_rx, input bit skip_cmd);
    int s_done, s_err, s_start, t;
    logic [SST-1:0] val;
    s_done  = n_done;
    s_err   = n_cerr;
    s_start = n_start;
    xor_out_stat = is_stat ? xerr : ~xerr;
    xor_out_dyn  = is_stat ? ~xerr : xerr;
    if (!skip_cmd) send_byte(is_stat ? 8'h53 : 8'h44);
    foreach (pl_q[i]) send_byte(pl_q[i]);
    n_vec++;
    if (start_ASIC_config !== 1'b1) begin
      n_err++;
      $display("FAIL start_latency: start=%0b want 1", start_ASIC_config);
    end
    n_vec++;
    if (flag_stat !== is_stat || flag_dyn !== !is_stat) begin
      n_err++;
      $display("FAIL flags: stat=%0b dyn=%0b want stat=%0b", flag_stat, flag_dyn, is_stat);
    end
    n_vec++;
    if (rx_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rx_ready_launch: got %0b want 0", rx_ready);
    end
    val = '0;
    foreach (pl_q[i]) val = {val[SST-9:0], pl_q[i]};
    if (is_stat) exp_stat = val;
    else exp_dyn = val[SDY-1:0];
    if (hold_rx) begin
      rx_data  = 8'h44;
      rx_valid = 1'b1;
    end
    for (int i = 0; i < end_delay; i++) begin
      @(negedge CLK);
      if (hold_rx) begin
        n_vec++;
        if (rx_ready !== 1'b0 || busy !== 1'b1) begin
          n_err++;
          $display("FAIL hold_wait_end: rx_ready=%0b busy=%0b want 0/1", rx_ready, busy);
        end
      end
    end
    end_config = 1'b1;
    t = 0;
    while (done !== 1'b1 && t < 10) begin
      @(negedge CLK);
      t++;
    end
    end_config = 1'b0;
    n_vec++;
    if (t >= 10) begin
      n_err++;
      $display("FAIL done_wait: no done within %0d cycles of end_config", t);
    end
    n_vec++;
    if (cfg_err !== xerr || (xerr && err_code !== 3'd1)) begin
      n_err++;
      $display("FAIL check_err: cfg_err=%0b code=%0d want %0b/1", cfg_err, err_code, xerr);
    end
    n_vec++;
    if (busy !== 1'b0 || rx_ready !== 1'b1) begin
      n_err++;
      $display("FAIL idle_after_done: busy=%0b rx_ready=%0b", busy, rx_ready);
    end
    n_vec++;
    if (static_conf_ear !== exp_stat || dynamic_conf !== exp_dyn) begin
      n_err++;
      $display("FAIL commit: stat=%h dyn=%h want %h %h", static_conf_ear, dynamic_conf,
               exp_stat, exp_dyn);
    end
    if (hold_rx) begin
      @(posedge CLK);
      @(negedge CLK);
      rx_valid = 1'b0;
      n_vec++;
      if (busy !== 1'b1 || flag_dyn !== 1'b0) begin
        n_err++;
        $display("FAIL held_byte: busy=%0b flag_dyn=%0b want 1/0", busy, flag_dyn);
      end
    end else begin
      @(negedge CLK);
    end
    n_vec++;
    if (n_done - s_done != 1 || n_start - s_start != 1 || n_cerr - s_err != int'(xerr)) begin
      n_err++;
      $display("FAIL pulse_count: done=%0d start=%0d err=%0d want 1 1 %0d",
               n_done - s_done, n_start - s_start, n_cerr - s_err, xerr);
    end
    xor_out_stat = 1'b0;
    xor_out_dyn  = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_vec++;
    if (static_conf_ear !== '0 || dynamic_conf !== '0 || err_code !== 3'd0) begin
      n_err++;
      $display("FAIL reset_regs: stat=%h dyn=%h code=%0d want 0", static_conf_ear,
               dynamic_conf, err_code);
    end
    n_vec++;
    if ({start_ASIC_config, done, cfg_err, busy, flag_stat, flag_dyn} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outs: start/done/err/busy/fs/fd=%06b want 0",
               {start_ASIC_config, done, cfg_err, busy, flag_stat, flag_dyn});
    end
    RST_N = 1'b1;
    @(negedge CLK);
    n_vec++;
    if (rx_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready: rx_ready=%0b busy=%0b want 1/0", rx_ready, busy);
    end
    exp_stat = '0;
    exp_dyn  = '0;
  endtask

  task automatic test_dyn_frame();
    pl_q = {};
    pl_q.push_back(8'hBE);
    pl_q.push_back(8'hEF);
    run_frame(1'b0, 40, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (dynamic_conf !== 16'hBEEF) begin
      n_err++;
      $display("FAIL dyn_beef: got %h want BEEF", dynamic_conf);
    end
  endtask

  task automatic test_stat_mismatch();
    pl_q = {};
    for (int i = 1; i <= SST / 8; i++) pl_q.push_back(8'(i));
    run_frame(1'b1, 10, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (static_conf_ear !== 88'h0102030405060708090A0B || dynamic_conf !== 16'hBEEF) begin
      n_err++;
      $display("FAIL stat_seq: stat=%h dyn=%h", static_conf_ear, dynamic_conf);
    end
    n_vec++;
    if (err_code !== 3'd1) begin
      n_err++;
      $display("FAIL mismatch_code_held: got %0d want 1", err_code);
    end
  endtask

  task automatic test_bad_cmd();
    logic [7:0] b;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) b = 8'h7E;
      else begin
        do b = 8'($urandom_range(0, 255)); while (b == 8'h53 || b == 8'h44);
      end
      send_byte(b);
      n_vec++;
      if (cfg_err !== 1'b1 || err_code !== 3'd4 || rx_ready !== 1'b1 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL bad_cmd %02h: err=%0b code=%0d ready=%0b busy=%0b", b, cfg_err,
                 err_code, rx_ready, busy);
      end
      @(negedge CLK);
      n_vec++;
      if (cfg_err !== 1'b0) begin
        n_err++;
        $display("FAIL bad_cmd_pulse: cfg_err=%0b want 0 one cycle later", cfg_err);
      end
    end
  endtask

  task automatic test_rx_hold();
    pl_q = {};
    pl_q.push_back(8'h12);
    pl_q.push_back(8'h34);
    run_frame(1'b0, 8, 1'b0, 1'b1, 1'b0);
    pl_q = {};
    pl_q.push_back(8'($urandom_range(0, 255)));
    pl_q.push_back(8'($urandom_range(0, 255)));
    run_frame(1'b0, 5, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_byte_timeout();
    int s_start, t;
    s_start = n_start;
    send_byte(8'h53);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)));
    t = 0;
    while (cfg_err !== 1'b1 && t < BTO + 20) begin
      @(negedge CLK);
      t++;
    end
    n_vec++;
    if (t < BTO || t > BTO + 2) begin
      n_err++;
      $display("FAIL byte_timeout_time: cfg_err after %0d cycles want %0d..%0d", t, BTO,
               BTO + 2);
    end
    n_vec++;
    if (err_code !== 3'd2 || busy !== 1'b0 || rx_ready !== 1'b1) begin
      n_err++;
      $display("FAIL byte_timeout_state: code=%0d busy=%0b ready=%0b want 2/0/1",
               err_code, busy, rx_ready);
    end
    n_vec++;
    if (n_start != s_start || static_conf_ear !== exp_stat || dynamic_conf !== exp_dyn) begin
      n_err++;
      $display("FAIL byte_timeout_outs: starts=%0d stat=%h dyn=%h", n_start - s_start,
               static_conf_ear, dynamic_conf);
    end
    @(negedge CLK);
    pl_q = {};
    pl_q.push_back(8'($urandom_range(0, 255)));
    pl_q.push_back(8'($urandom_range(0, 255)));
    run_frame(1'b0, 3, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_end_timeout();
    int s_done, t;
    logic [7:0] b0, b1;
    s_done = n_done;
    b0 = 8'($urandom_range(0, 255));
    b1 = 8'($urandom_range(0, 255));
    end_config = 1'b1;
    send_byte(8'h44);
    send_byte(b0);
    send_byte(b1);
    exp_dyn = {b0, b1};
    n_vec++;
    if (start_ASIC_config !== 1'b1) begin
      n_err++;
      $display("FAIL end_to_start: start=%0b want 1", start_ASIC_config);
    end
    t = 0;
    while (cfg_err !== 1'b1 && t < ETO + 20) begin
      @(negedge CLK);
      t++;
    end
    n_vec++;
    if (t < ETO || t > ETO + 3) begin
      n_err++;
      $display("FAIL end_timeout_time: cfg_err after %0d cycles want %0d..%0d", t, ETO,
               ETO + 3);
    end
    n_vec++;
    if (err_code !== 3'd3 || busy !== 1'b0 || dynamic_conf !== exp_dyn) begin
      n_err++;
      $display("FAIL end_timeout_state: code=%0d busy=%0b dyn=%h want 3/0/%h", err_code,
               busy, dynamic_conf, exp_dyn);
    end
    end_config = 1'b0;
    @(negedge CLK);
    n_vec++;
    if (n_done != s_done) begin
      n_err++;
      $display("FAIL end_timeout_done: %0d done pulses want 0", n_done - s_done);
    end
  endtask

  task automatic test_reset_mid();
    int s_done, s_err;
    s_done = n_done;
    s_err  = n_cerr;
    send_byte(8'h53);
    send_byte(8'hA5);
    send_byte(8'h5A);
    RST_N = 1'b0;
    @(negedge CLK);
    n_vec++;
    if (busy !== 1'b0 || static_conf_ear !== '0 || dynamic_conf !== '0 ||
        err_code !== 3'd0 || rx_ready !== 1'b1 ||
        {start_ASIC_config, done, cfg_err, flag_stat, flag_dyn} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_mid_load: busy=%0b stat=%h dyn=%h code=%0d ready=%0b", busy,
               static_conf_ear, dynamic_conf, err_code, rx_ready);
    end
    RST_N = 1'b1;
    exp_stat = '0;
    exp_dyn  = '0;
    send_byte(8'h44);
    send_byte(8'h77);
    send_byte(8'h88);
    repeat (3) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    n_vec++;
    if (busy !== 1'b0 || dynamic_conf !== '0 || flag_dyn !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_wait: busy=%0b dyn=%h flag_dyn=%0b want 0", busy,
               dynamic_conf, flag_dyn);
    end
    repeat (5) @(negedge CLK);
    n_vec++;
    if (n_done != s_done || n_cerr != s_err) begin
      n_err++;
      $display("FAIL reset_abort_pulses: done=%0d err=%0d want 0 0", n_done - s_done,
               n_cerr - s_err);
    end
  endtask

  task automatic test_random_frames();
    bit is_stat;
    for (int f = 0; f < 12; f++) begin
      is_stat = 1'($urandom_range(0, 1));
      pl_q = {};
      for (int i = 0; i < (is_stat ? SST / 8 : SDY / 8); i++)
        pl_q.push_back(8'($urandom_range(0, 255)));
      run_frame(is_stat, int'($urandom_range(1, 30)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_dyn_frame();
    test_stat_mismatch();
    test_bad_cmd();
    test_rx_hold();
    test_byte_timeout();
    test_end_timeout();
    test_reset_mid();
    test_random_frames();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/asic_cfg_loader.md
ASIC_CFG_LOADER -- requirements
Module: asic_cfg_loader

Interface
REQ-001 Parameter SIZESRSTAT, default 88: static configuration width in bits, whole bytes only.
REQ-002 Parameter SIZESRDYN, default 16: dynamic configuration width in bits, whole bytes only.
REQ-003 Parameter BYTE_TIMEOUT, default 16000: maximum CLK cycles between bytes of one frame (1 ms at 16 MHz).
REQ-004 Parameter END_TIMEOUT, default 65535: maximum CLK cycles to wait for end_config.
REQ-005 CLK  in  1  single system clock (16 MHz); all logic on its rising edge.
REQ-006 RST_N  in  1  reset, synchronous and active-low.
REQ-007 rx_data  in  8  host command/payload byte.
REQ-008 rx_valid  in  1  rx_data valid; a byte transfers when rx_valid and rx_ready are high on the same edge.
REQ-009 rx_ready  out  1  loader accepts a byte.
REQ-010 static_conf_ear  out  SIZESRSTAT  committed static configuration, driven to the bridge.
REQ-011 dynamic_conf  out  SIZESRDYN  committed dynamic configuration, driven to the bridge.
REQ-012 flag_stat  out  1  current launch writes the static register.
REQ-013 flag_dyn  out  1  current launch writes the dynamic register.
REQ-014 start_ASIC_config  out  1  one-cycle launch pulse to the bridge.
REQ-015 end_config  in  1  bridge completion; its rising edge ends a launch.
REQ-016 xor_out_stat / xor_out_dyn  in  1 each  bridge readback mismatch (1 = error).
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse when a launch completes.
REQ-019 cfg_err  out  1  one-cycle pulse on readback mismatch, byte timeout, end timeout or unknown command.
REQ-020 err_code  out  3  cause of the last cfg_err: 1 = mismatch, 2 = byte timeout, 3 = end timeout, 4 = bad command; held until the next cfg_err.

Function
REQ-021 The FSM SHALL have the states IDLE, LOAD, LAUNCH, WAIT_END and CHECK.
REQ-022 IDLE: rx_ready=1; byte 0x53 -> LOAD(static, N=SIZESRSTAT/8); byte 0x44 -> LOAD(dynamic, N=SIZESRDYN/8); any other byte -> cfg_err with code 4, remain in IDLE.
REQ-023 LOAD: rx_ready=1; each accepted byte shifts MSB-first into a shadow register (first byte lands in the top byte); after byte N -> LAUNCH.
REQ-024 LOAD: byte counter reaches BYTE_TIMEOUT with no transfer -> cfg_err with code 2, go to IDLE; shadow discarded; committed outputs unchanged.
REQ-025 LAUNCH (exactly 1 cycle): copy the shadow into the selected output register; assert start_ASIC_config; set flag_stat or flag_dyn per target, the other flag 0; -> WAIT_END.
REQ-026 The flags SHALL hold from LAUNCH until the exit from CHECK; in IDLE and LOAD both flags SHALL be 0.
REQ-027 rx_ready SHALL be 0 in LAUNCH, WAIT_END and CHECK; rx_valid in these states is ignored and no byte is lost or consumed.
REQ-028 WAIT_END: rising edge of end_config (registered previous value was 0) -> CHECK; an end_config already high on entry SHALL NOT count.
REQ-029 WAIT_END: END_TIMEOUT cycles without the edge -> cfg_err with code 3, go to IDLE, no done pulse.
REQ-030 CHECK (1 cycle): sample xor_out_stat if the static flag is set, else xor_out_dyn; value 1 -> cfg_err with code 1; always pulse done; -> IDLE.
REQ-031 Latency: the last payload byte accepted at edge k SHALL give start_ASIC_config high in cycle k+1.
REQ-032 Counter widths SHALL be ceil(log2(timeout+1)); counters SHALL saturate, never wrap.
REQ-033 Only the targeted output register changes in a launch; the other keeps its value.

Reset
REQ-034 RST_N low at an edge SHALL force IDLE, clear static_conf_ear, dynamic_conf, the shadow, the counters and err_code, and drive all outputs to 0 except rx_ready, which is 1 from the first cycle after reset.
REQ-035 Reset mid-LOAD or mid-WAIT_END SHALL abort without a cfg_err or done pulse.

Structure
REQ-036 Package asic_bridge_pkg SHALL hold the command codes 0x53/0x44, the err_code values and the state encoding.
REQ-037 The shadow register and byte counter SHALL form one sub-module, cfg_frame_shifter (parallel load, byte shift, count-complete flag); all other logic stays in asic_cfg_loader.

Verification
REQ-038 Send 0x44,0xBE,0xEF, end_config rising 40 cycles after the start pulse, xor_out_dyn=0 -> dynamic_conf=16'hBEEF, flag_dyn=1, start pulse in the cycle after 0xEF, one done pulse, no cfg_err.
REQ-039 Send 0x53 + 11 bytes 0x01..0x0B, xor_out_stat=1 -> static_conf_ear=88'h0102030405060708090A0B, done pulse, cfg_err with err_code=1, dynamic_conf unchanged.
REQ-040 Send 0x53, 3 bytes, then idle 16000 cycles -> cfg_err with code 2, no start pulse, outputs unchanged, a following 0x44 frame succeeds.
REQ-041 Send 0x7E -> cfg_err with code 4, rx_ready stays 1; rx_valid held high during WAIT_END -> the byte is not accepted until IDLE.
REQ-042 end_config held high through the launch, or never asserted -> cfg_err with code 3 after 65535 cycles; RST_N low mid-LOAD -> IDLE, outputs 0, no pulses.
